// File: rtl/midi_pkg.sv
// midi_pkg: parser states, MIDI byte-class limits and channel-message data length
package midi_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} midi_state_t;
    localparam logic [7:0] RT_MIN = 8'hF8;
    localparam logic [7:0] SYS_MIN = 8'hF0;
    function automatic logic [1:0] midi_data_len(input logic [7:0] status);
        return (status >= 8'hC0 && status < 8'hE0) ? 2'd1 : 2'd2;
    endfunction
endpackage

// File: rtl/midi_hold_timer.sv
// midi_hold_timer: reloadable down-counter (clk, rst_n, load) pulsing expired on the cycle it reaches zero
module midi_hold_timer #(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int CNT_W = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expired
);
    logic [CNT_W-1:0] cnt;
    assign expired = !load && cnt == CNT_W'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= CNT_W'(HOLD_CYCLES);
        else if (cnt != '0) cnt <= cnt - CNT_W'(1);
    end
endmodule

// File: rtl/midi_msg_display.sv
// midi_msg_display: parses MIDI channel messages (rx_byte, rx_valid) into hex_nib, digit_en, msg_strobe, msg_count
module midi_msg_display
    import midi_pkg::*;
#(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int CNT_W = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [23:0] hex_nib,
    output logic [5:0]  digit_en,
    output logic        msg_strobe,
    output logic [7:0]  msg_count
);
    midi_state_t state, state_nx;
    logic [7:0] run_st, run_st_nx, d1, d1_nx;
    logic done, full, expired;
    midi_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES), .CNT_W(CNT_W)) u_hold (
        .clk(clk),
        .rst_n(rst_n),
        .load(done),
        .expired(expired)
    );
    // real-time bytes fall through untouched, so they are invisible even mid-message
    always_comb begin
        state_nx = state;
        run_st_nx = run_st;
        d1_nx = d1;
        done = 1'b0;
        full = midi_data_len(run_st) == 2'd2;
        if (rx_valid && rx_byte < RT_MIN) begin
            if (rx_byte >= SYS_MIN) begin
                state_nx = IDLE;
                run_st_nx = '0;
            end else if (rx_byte[7]) begin
                state_nx = WAIT_D1;
                run_st_nx = rx_byte;
            end else if (state == WAIT_D1) begin
                d1_nx = rx_byte;
                done = !full;
                state_nx = full ? WAIT_D2 : WAIT_D1;
            end else if (state == WAIT_D2) begin
                done = 1'b1;
                state_nx = WAIT_D1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_st <= '0;
            d1 <= '0;
            hex_nib <= '0;
            digit_en <= '0;
            msg_strobe <= 1'b0;
            msg_count <= '0;
        end else begin
            run_st <= run_st_nx;
            d1 <= d1_nx;
            msg_strobe <= done;
            if (done) begin
                hex_nib <= full ? {run_st, d1, rx_byte} : {run_st, rx_byte, 8'h00};
                digit_en <= full ? 6'b111111 : 6'b111100;
                msg_count <= msg_count + 8'd1;
            end else if (expired) begin
                digit_en <= '0;
            end
        end
    end
endmodule

// File: tb/tb_midi_msg_display.sv
// tb_midi_msg_display: table-driven and scoreboard checks of the MIDI message display parser
module tb_midi_msg_display;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rx_valid = 1'b0;
    logic [7:0] rx_byte = '0;
    logic [23:0] hex_nib;
    logic [5:0] digit_en;
    logic msg_strobe;
    logic [7:0] msg_count;
    int tests = 0;
    int fails = 0;
    typedef struct {
        logic [7:0]  b;
        bit          done;
        logic [23:0] hex;
        logic [5:0]  en;
    } vec_t;
    typedef struct {
        logic [23:0] hex;
        logic [5:0]  en;
        logic [7:0]  cnt;
    } exp_t;
    exp_t sb[$];
    logic [7:0] exp_cnt = '0;
    vec_t vt[23];

    midi_msg_display #(.HOLD_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_byte(rx_byte),
        .rx_valid(rx_valid),
        .hex_nib(hex_nib),
        .digit_en(digit_en),
        .msg_strobe(msg_strobe),
        .msg_count(msg_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic expect_msg(input logic [23:0] hex, input logic [5:0] en);
        exp_cnt = exp_cnt + 8'd1;
        sb.push_back('{hex, en, exp_cnt});
    endtask

    // called at a negedge; returns at the next negedge with the byte consumed
    task automatic send(input logic [7:0] b);
        rx_byte = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (msg_strobe === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: hex_nib %h count %h", hex_nib, msg_count);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_hex", hex_nib, e.hex);
                check("sb_en", digit_en, e.en);
                check("sb_count", msg_count, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{8'h90, 1'b0, 24'h000000, 6'h00};
        vt[1]  = '{8'h3C, 1'b0, 24'h000000, 6'h00};
        vt[2]  = '{8'h64, 1'b1, 24'h903C64, 6'h3F};
        vt[3]  = '{8'h40, 1'b0, 24'h903C64, 6'h3F};
        vt[4]  = '{8'h00, 1'b1, 24'h904000, 6'h3F};
        vt[5]  = '{8'hC5, 1'b0, 24'h904000, 6'h3F};
        vt[6]  = '{8'h07, 1'b1, 24'hC50700, 6'h3C};
        vt[7]  = '{8'h09, 1'b1, 24'hC50900, 6'h3C};
        vt[8]  = '{8'h90, 1'b0, 24'hC50900, 6'h3C};
        vt[9]  = '{8'h3C, 1'b0, 24'hC50900, 6'h3C};
        vt[10] = '{8'hF8, 1'b0, 24'hC50900, 6'h3C};
        vt[11] = '{8'h64, 1'b1, 24'h903C64, 6'h3F};
        vt[12] = '{8'h90, 1'b0, 24'h903C64, 6'h3F};
        vt[13] = '{8'h3C, 1'b0, 24'h903C64, 6'h3F};
        vt[14] = '{8'hB0, 1'b0, 24'h903C64, 6'h3F};
        vt[15] = '{8'h07, 1'b0, 24'h903C64, 6'h3F};
        vt[16] = '{8'hFF, 1'b0, 24'h903C64, 6'h3F};
        vt[17] = '{8'h7F, 1'b1, 24'hB0077F, 6'h3F};
        vt[18] = '{8'hF0, 1'b0, 24'hB0077F, 6'h3F};
        vt[19] = '{8'h3C, 1'b0, 24'hB0077F, 6'h3F};
        vt[20] = '{8'h64, 1'b0, 24'hB0077F, 6'h3F};
        vt[21] = '{8'hD3, 1'b0, 24'hB0077F, 6'h3F};
        vt[22] = '{8'h55, 1'b1, 24'hD35500, 6'h3C};

        #1 rst_n = 1'b0;
        #10;
        check("rst_hex", hex_nib, 24'h0);
        check("rst_en", digit_en, 6'h0);
        check("rst_strobe", msg_strobe, 1'b0);
        check("rst_count", msg_count, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 23; i++) begin
            if (vt[i].done) expect_msg(vt[i].hex, vt[i].en);
            send(vt[i].b);
            check($sformatf("vec%0d_strobe", i), msg_strobe, vt[i].done);
            check($sformatf("vec%0d_hex", i), hex_nib, vt[i].hex);
            check($sformatf("vec%0d_en", i), digit_en, vt[i].en);
        end

        repeat (12) @(negedge clk);
        check("idle_blank_en", digit_en, 6'h0);
        check("idle_keep_hex", hex_nib, 24'hD35500);

        send(8'h90);
        send(8'h3C);
        expect_msg(24'h903C64, 6'h3F);
        send(8'h64);
        check("hold_strobe", msg_strobe, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) check("hold_strobe_width", msg_strobe, 1'b0);
            check($sformatf("hold_en_k%0d", k), digit_en, k < 10 ? 6'h3F : 6'h00);
        end

        send(8'h90);
        send(8'h3C);
        expect_msg(24'h903C64, 6'h3F);
        send(8'h64);
        repeat (7) @(negedge clk);
        send(8'h91);
        send(8'h3C);
        expect_msg(24'h913C64, 6'h3F);
        send(8'h64);
        check("collide_en", digit_en, 6'h3F);
        repeat (9) @(negedge clk);
        check("collide_en_n9", digit_en, 6'h3F);
        @(negedge clk);
        check("collide_en_n10", digit_en, 6'h00);

        send(8'h92);
        send(8'h3C);
        rst_n = 1'b0;
        exp_cnt = '0;
        #1;
        check("midrst_hex", hex_nib, 24'h0);
        check("midrst_en", digit_en, 6'h0);
        check("midrst_count", msg_count, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h64);
        repeat (3) @(negedge clk);
        check("postrst_hex", hex_nib, 24'h0);
        check("postrst_count", msg_count, 8'h0);

        send(8'hC0);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] d;
            d = {1'b0, 7'(i)};
            expect_msg({8'hC0, d, 8'h00}, 6'h3C);
            send(d);
        end
        check("count_wrap", msg_count, 8'h00);
        repeat (3) @(negedge clk);
        check("sb_pending", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/midi_msg_display.md
Name: midi_msg_display

Overview:
- Upstream stage of the per-digit seven-segment decoders on the MIDI board.
- Consumes the received MIDI byte stream and parses channel-voice messages, including running status.
- Latches the last complete message and presents it as six hex nibbles (status, data1, data2), one per decoder.
- Provides per-digit enables and an activity hold timer, so the display blanks after a period with no MIDI traffic.

Parameters:
- HOLD_CYCLES, 25_000_000: clock cycles the display stays lit after the last complete message (0.5 s at 50 MHz).
- CNT_W, 25: width of the hold counter; must satisfy 2**CNT_W > HOLD_CYCLES.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- rx_byte  in  8  received MIDI byte.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid this cycle.
- hex_nib  out  24  six nibbles for the decoders; [23:20]=digit5 ... [3:0]=digit0.
- digit_en  out  6  per-digit enable; 0 means the top level forces that digit's segments to 7'h7F (off).
- msg_strobe  out  1  one-cycle pulse when a complete message is latched.
- msg_count  out  8  count of complete messages, wraps 255->0.

Behaviour:
- Reset (async assert, sync release by the top level):
  - hex_nib=0, digit_en=0, msg_strobe=0, msg_count=0.
  - Parser in state IDLE; running status cleared; hold counter = 0.
- Byte classes (evaluated only when rx_valid=1; nothing changes when rx_valid=0):
  - 0xF8-0xFF real-time: ignored completely. No state change and no running-status change, even mid-message.
  - 0xF0-0xF7 system common/SysEx: clear running status and go to IDLE. Not displayed.
  - 0x80-0xEF channel status: store as running status. Abort any partial message.
    - Next state WAIT_D1.
    - Data length is 1 for 0xC_/0xD_ and 2 for all other channel statuses.
  - 0x00-0x7F data byte: handled per state, below.
- Parser state machine:
  - IDLE: data byte discarded; stay in IDLE.
  - WAIT_D1: data byte is stored as d1.
    - 2-byte message: go to WAIT_D2.
    - 1-byte message: message complete; go to WAIT_D1, reusing running status.
  - WAIT_D2: data byte is stored as d2; message complete; go to WAIT_D1 (running status).
- Message complete (takes effect at the clock edge after the final byte's rx_valid cycle):
  - hex_nib <= {status, d1, d2}. For 1-byte messages d2 is shown as 0x00.
  - digit_en <= 6'b111111 for 2-byte messages, 6'b111100 for 1-byte messages.
  - msg_strobe high for exactly that one cycle.
  - msg_count += 1, wrapping modulo 256.
  - Hold counter loaded with HOLD_CYCLES.
- Latency: one cycle from the final byte's rx_valid to updated outputs.
- Hold timer:
  - Decrements each cycle while nonzero.
  - On the cycle it reaches 0, digit_en <= 0; hex_nib keeps its value.
  - A completion on the same cycle as expiry wins: the counter reloads and the digits stay lit.
- Status byte received mid-message: the partial message is dropped with no strobe and the display is unchanged.
- Reset asserted mid-message: the partial message is lost and all outputs return to reset values immediately.

Decomposition:
- Package midi_pkg holds:
  - parser state enum (IDLE, WAIT_D1, WAIT_D2);
  - byte-class constants (RT_MIN=8'hF8, SYS_MIN=8'hF0);
  - function midi_data_len(status) returning 1 or 2.
- One natural sub-module, midi_hold_timer: load/decrement counter with an expired pulse, parameterised by HOLD_CYCLES.
- Parser and output registers stay in the top module.

Test Plan:
- 0x90,0x3C,0x64 -> one cycle after the last byte:
  - hex_nib=24'h903C64, digit_en=6'h3F, msg_strobe pulses once, msg_count=1.
- Running status 0x90,0x3C,0x64 then 0x40,0x00 -> second strobe, hex_nib=24'h904000, msg_count=2.
- 0xC5,0x07 -> hex_nib=24'hC50700, digit_en=6'b111100. A following 0x09 -> hex_nib=24'hC50900.
- 0x90,0x3C,0xF8,0x64 -> same result as the first case; the real-time byte is invisible.
- 0x90,0x3C,0xB0,0x07,0x7F -> no strobe for the aborted 0x90 message, then hex_nib=24'hB0077F.
- 0xF0 then 0x3C -> no strobe and display unchanged.
- HOLD_CYCLES=10:
  - digit_en drops to 0 exactly 10 cycles after msg_strobe;
  - a new message arriving on the expiry cycle keeps the digits lit;
  - rst_n pulsed low mid-message -> all outputs are 0 and the next data byte is ignored.
